count_frame_buffer: RTL and testbench
=====================================

Name: count_frame_buffer

Overview:
- Downstream stage of the photon counter.
- Captures each per-bin count sample (COUNTER qualified by INTR) while GATE is high and stores one gate window as a frame of up to DEPTH samples.
- After GATE falls, streams the frame out over a valid/ready interface with a last flag, to the FNN feature loader / PS DMA.

Parameters:
- WIDTH, 8, width of the count samples and of M_DATA.
- DEPTH, 16, maximum samples per frame (power of 2, ≥2).
- ADDR_W, $clog2(DEPTH), buffer address width (localparam).

Ports:
- CLK  in  1  system clock, 100 MHz
- RST_N  in  1  reset; asynchronous assert, active-low
- GATE  in  1  measurement window; the same signal the counter uses
- INTR  in  1  one-cycle sample strobe from the counter
- COUNTER  in  WIDTH  count sample; valid when INTR=1
- M_DATA  out  WIDTH  streamed sample
- M_VALID  out  1  M_DATA valid
- M_READY  in  1  consumer accepts
- M_LAST  out  1  final sample of the frame; qualified by M_VALID
- FRAME_LEN  out  ADDR_W+1  number of samples in the current or last frame
- OVERFLOW  out  1  sticky: the frame had more than DEPTH strobes
- BUSY  out  1  high in CAPTURE or DRAIN

Behaviour:
- Reset: all outputs 0, state IDLE, write/read pointers 0. Buffer contents are don't-care.
- Gate edge detection uses a 1-cycle registered copy of GATE, reset to 0.
- State IDLE:
  - On GATE rise (GATE=1, previous GATE=0): go to CAPTURE, clear wr_ptr, FRAME_LEN and OVERFLOW.
  - GATE already high out of reset, with no edge, does not start a frame.
- State CAPTURE:
  - Each cycle with INTR=1 and GATE=1: write COUNTER to buf[wr_ptr], increment wr_ptr and FRAME_LEN.
  - If FRAME_LEN==DEPTH: do not write, set OVERFLOW, leave FRAME_LEN saturated at DEPTH.
  - INTR while GATE=0 is ignored.
- CAPTURE exit on GATE fall:
  - FRAME_LEN>0: go to DRAIN, rd_ptr=0.
  - FRAME_LEN==0: return to IDLE; no stream output.
- State DRAIN (registered read):
  - M_VALID rises the cycle after entering DRAIN with M_DATA=buf[0].
  - A beat transfers when M_VALID & M_READY. After a transfer the next sample is presented the next cycle; throughput is 1 beat/cycle when M_READY is held high.
  - M_DATA and M_LAST stay stable while M_VALID=1 and M_READY=0.
  - M_LAST=1 exactly on the beat with rd_ptr==FRAME_LEN-1.
  - Transfer of the last beat: M_VALID drops the next cycle and the state returns to IDLE.
- GATE rise during DRAIN is ignored and that window is lost. A new frame needs a fresh rise seen in IDLE.
- FRAME_LEN and OVERFLOW hold after DRAIN until the next frame starts.
- Asynchronous reset mid-CAPTURE or mid-DRAIN: immediate return to the reset state; partial frame discarded.
- No combinational path from M_READY to M_VALID.

Optional Feature:
- Macro COUNT_SUM_EN.
- Defined:
  - Adds parameter THRESH (default 4) and outputs SUM (WIDTH+ADDR_W bits) and STATE_BIT (1).
  - SUM accumulates every stored sample; dropped overflow samples are excluded.
  - SUM is cleared at frame start.
  - STATE_BIT = (SUM > THRESH), registered when CAPTURE exits, held until the next frame start.
  - Reset value 0 for both outputs.
- Undefined: ports, accumulator and comparator are absent; streaming behaviour is identical.

Decomposition:
- Shared package cnt_pkg: state enum {IDLE, CAPTURE, DRAIN}, default WIDTH/DEPTH constants, a clog2 helper.
- Sub-module sample_ram (DEPTH×WIDTH):
  - One write port, one synchronous read port.
  - Inferable as distributed RAM.
  - Its synchronous read defines the 1-cycle DRAIN latency.

Test Plan:
- Basic frame: GATE high for 4 strobes with COUNTER=3,0,7,255, then GATE low, M_READY=1 → beats 3,0,7,255 on consecutive cycles, M_LAST on 255, FRAME_LEN=4, OVERFLOW=0.
- Backpressure: same frame, M_READY toggled 1,0,0,1,… → no beat lost or duplicated; M_DATA/M_LAST stable while stalled.
- Overflow: DEPTH=16, 20 strobes in one gate → 16 beats streamed (first 16 values), FRAME_LEN=16, OVERFLOW=1; next frame clears OVERFLOW.
- Empty gate: GATE high for 100 cycles with no INTR → no M_VALID, BUSY returns low one cycle after the GATE fall.
- Gate during drain: M_READY=0, re-raise GATE while in DRAIN, send strobes → those strobes are ignored; the original frame drains intact.
- Reset mid-drain, plus COUNT_SUM_EN: RST_N low after 2 of 4 beats → all outputs 0 at once. With COUNT_SUM_EN and THRESH=4, samples 1,2,2 → SUM=5, STATE_BIT=1; samples 1,1 → STATE_BIT=0.

Source files
------------

// File: rtl/cnt_pkg.sv
// cnt_pkg: shared types and defaults for the count frame buffer.
package cnt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  localparam int CNT_WIDTH = 8;
  localparam int CNT_DEPTH = 16;

  // Ceiling log2, usable in constant expressions (value >= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sample_ram.sv
// sample_ram: DEPTH x WIDTH buffer, one write port, one registered read port.
// The array has no reset so it maps onto distributed RAM; only the read
// register is reset so the streamed data output starts at 0.
module sample_ram
  import cnt_pkg::*;
#(
  parameter int WIDTH  = CNT_WIDTH,
  parameter int DEPTH  = CNT_DEPTH,
  parameter int ADDR_W = clog2(CNT_DEPTH)
)(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Write port.
  always_ff @(posedge CLK) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Synchronous read; output holds when no read is issued.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/count_frame_buffer.sv
// count_frame_buffer: captures counter samples during a GATE window into a
// frame buffer, then streams the frame out over valid/ready with a last flag.
// Optional macro COUNT_SUM_EN adds a per-frame sample sum (SUM) and a
// threshold flag (STATE_BIT) latched when capture ends.
module count_frame_buffer
  import cnt_pkg::*;
#(
  parameter int WIDTH  = CNT_WIDTH,
  parameter int DEPTH  = CNT_DEPTH,
`ifdef COUNT_SUM_EN
  parameter int THRESH = 4,
`endif
  localparam int ADDR_W = clog2(DEPTH)
)(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              GATE,
  input  logic              INTR,
  input  logic [WIDTH-1:0]  COUNTER,
  output logic [WIDTH-1:0]  M_DATA,
  output logic              M_VALID,
  input  logic              M_READY,
  output logic              M_LAST,
  output logic [ADDR_W:0]   FRAME_LEN,
  output logic              OVERFLOW,
  output logic              BUSY
`ifdef COUNT_SUM_EN
  ,
  output logic [WIDTH+ADDR_W-1:0] SUM,
  output logic                    STATE_BIT
`endif
);

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);

  state_t            r_state, w_next;
  logic              r_gate_d;
  logic              r_gate_armed;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W:0]   r_len;
  logic              r_ovf;
  logic [ADDR_W:0]   r_rd_ptr;
  logic              r_valid;
  logic              r_last;
  logic [WIDTH-1:0]  w_rdata;

  logic w_rise, w_start, w_in_cap, w_in_drain, w_busy;
  logic w_cap_exit, w_strobe, w_full, w_we;
  logic w_xfer, w_last_xfer, w_load;

  // A rise only counts once the gate history holds a real sample; this keeps
  // a GATE already high when reset releases from opening a frame.
  assign w_rise      = GATE & ~r_gate_d & r_gate_armed;
  assign w_cap_exit  = w_in_cap & ~GATE;
  assign w_strobe    = w_in_cap & INTR & GATE;
  assign w_full      = (r_len == LEN_MAX);
  assign w_we        = w_strobe & ~w_full;
  assign w_xfer      = r_valid & M_READY;
  assign w_last_xfer = w_xfer & r_last;
  // Fetch the next sample on DRAIN entry and after every non-final beat.
  assign w_load      = w_in_drain & (~r_valid | (w_xfer & ~r_last));

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_rise) w_next = CAPTURE;
      CAPTURE: if (!GATE) w_next = (r_len != '0) ? DRAIN : IDLE;
      DRAIN:   if (w_last_xfer) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State decodes.
  always_comb begin
    w_in_cap   = (r_state == CAPTURE);
    w_in_drain = (r_state == DRAIN);
    w_busy     = (r_state != IDLE);
    w_start    = (r_state == IDLE) & w_rise;
  end

  // Gate history for edge detection.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_gate_d     <= 1'b0;
      r_gate_armed <= 1'b0;
    end else begin
      r_gate_d     <= GATE;
      r_gate_armed <= 1'b1;
    end
  end

  // Capture bookkeeping: write pointer, saturating length, sticky overflow.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_len    <= '0;
      r_ovf    <= 1'b0;
    end else if (w_start) begin
      r_wr_ptr <= '0;
      r_len    <= '0;
      r_ovf    <= 1'b0;
    end else if (w_strobe) begin
      if (w_full) begin
        r_ovf <= 1'b1;
      end else begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_len    <= r_len + 1'b1;
      end
    end
  end

  // Drain side: read pointer, output valid and last flag.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rd_ptr <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
    end else if (w_cap_exit) begin
      r_rd_ptr <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
    end else if (w_load) begin
      r_rd_ptr <= r_rd_ptr + 1'b1;
      r_valid  <= 1'b1;
      r_last   <= (r_rd_ptr == (r_len - 1'b1));
    end else if (w_last_xfer) begin
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
    end
  end

  sample_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (COUNTER),
    .i_re    (w_load),
    .i_raddr (r_rd_ptr[ADDR_W-1:0]),
    .o_rdata (w_rdata)
  );

  assign M_DATA    = w_rdata;
  assign M_VALID   = r_valid;
  assign M_LAST    = r_last & r_valid;
  assign FRAME_LEN = r_len;
  assign OVERFLOW  = r_ovf;
  assign BUSY      = w_busy;

`ifdef COUNT_SUM_EN
  logic [WIDTH+ADDR_W-1:0] r_sum;
  logic                    r_state_bit;

  // Sum of stored samples; threshold flag latched as capture ends.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sum       <= '0;
      r_state_bit <= 1'b0;
    end else if (w_start) begin
      r_sum       <= '0;
      r_state_bit <= 1'b0;
    end else begin
      if (w_we)       r_sum       <= r_sum + (WIDTH+ADDR_W)'(COUNTER);
      if (w_cap_exit) r_state_bit <= (r_sum > (WIDTH+ADDR_W)'(THRESH));
    end
  end

  assign SUM       = r_sum;
  assign STATE_BIT = r_state_bit;
`endif

endmodule

// File: tb/tb_count_frame_buffer.sv
// tb_count_frame_buffer: directed vectors with hand-computed expectations.
module tb_count_frame_buffer;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        GATE = 1'b0;
  logic        INTR = 1'b0;
  logic [7:0]  COUNTER = 8'd0;
  logic        M_READY = 1'b0;
  logic [7:0]  M_DATA;
  logic        M_VALID;
  logic        M_LAST;
  logic [4:0]  FRAME_LEN;
  logic        OVERFLOW;
  logic        BUSY;
`ifdef COUNT_SUM_EN
  logic [11:0] SUM;
  logic        STATE_BIT;
`endif

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [7:0] stim [0:31];

  always #5 CLK = ~CLK;

  count_frame_buffer #(.WIDTH(8), .DEPTH(16)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .GATE      (GATE),
    .INTR      (INTR),
    .COUNTER   (COUNTER),
    .M_DATA    (M_DATA),
    .M_VALID   (M_VALID),
    .M_READY   (M_READY),
    .M_LAST    (M_LAST),
    .FRAME_LEN (FRAME_LEN),
    .OVERFLOW  (OVERFLOW),
    .BUSY      (BUSY)
`ifdef COUNT_SUM_EN
    ,
    .SUM       (SUM),
    .STATE_BIT (STATE_BIT)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge CLK);
  endtask

  // Open a gate window and strobe stim[0..n-1] on consecutive cycles.
  task automatic capture(input int n);
    GATE = 1'b1;
    tick;
    chk("cap_busy", 32'(BUSY), 1);
    for (int i = 0; i < n; i++) begin
      COUNTER = stim[i];
      INTR    = 1'b1;
      tick;
    end
    INTR = 1'b0;
    tick;
  endtask

  // Close the gate; the next cycle is the first DRAIN cycle with no data yet.
  task automatic gate_fall;
    GATE = 1'b0;
    tick;
    chk("drn_entry_busy", 32'(BUSY), 1);
    chk("drn_entry_valid", 32'(M_VALID), 0);
  endtask

  // Expect stim[0..n-1]; mode 0 holds ready high, mode 1 uses ready 1,0,0,...
  task automatic drain(input int n, input int mode);
    int   idx;
    logic rdy;
    idx = 0;
    for (int cyc = 0; cyc < 200 && idx < n; cyc++) begin
      tick;
      if (cyc == 0)  chk("first_valid", 32'(M_VALID), 1);
      if (mode == 0) chk("tput_valid", 32'(M_VALID), 1);
      if (M_VALID) begin
        chk("beat_data", 32'(M_DATA), 32'(stim[idx]));
        chk("beat_last", 32'(M_LAST), (idx == n - 1) ? 32'd1 : 32'd0);
      end
      rdy = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      M_READY = rdy;
      if (M_VALID && rdy) idx++;
    end
    if (idx < n) chk("drain_timeout", 32'(idx), 32'(n));
    tick;
    M_READY = 1'b0;
    chk("end_valid", 32'(M_VALID), 0);
    chk("end_busy", 32'(BUSY), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw;

    // Reset state, with GATE already high before release.
    GATE = 1'b1;
    tick;
    chk("rst_valid", 32'(M_VALID), 0);
    chk("rst_data", 32'(M_DATA), 0);
    chk("rst_last", 32'(M_LAST), 0);
    chk("rst_len", 32'(FRAME_LEN), 0);
    chk("rst_ovf", 32'(OVERFLOW), 0);
    chk("rst_busy", 32'(BUSY), 0);
    RST_N = 1'b1;
    repeat (5) tick;
    chk("gate_high_oor", 32'(BUSY), 0);
    GATE = 1'b0;
    tick;

    // Basic frame, ready always high.
    stim[0] = 8'd3; stim[1] = 8'd0; stim[2] = 8'd7; stim[3] = 8'd255;
    capture(4);
    chk("basic_len", 32'(FRAME_LEN), 4);
    chk("basic_ovf", 32'(OVERFLOW), 0);
    gate_fall;
    drain(4, 0);
    chk("basic_len_hold", 32'(FRAME_LEN), 4);

    // Same frame under backpressure.
    capture(4);
    gate_fall;
    drain(4, 1);

    // Overflow: 20 strobes, first 16 kept.
    for (int i = 0; i < 20; i++) stim[i] = 8'(i * 11 + 1);
    capture(20);
    chk("ovf_len", 32'(FRAME_LEN), 16);
    chk("ovf_flag", 32'(OVERFLOW), 1);
    gate_fall;
    drain(16, 0);
    chk("ovf_hold", 32'(OVERFLOW), 1);
    stim[0] = 8'd42; stim[1] = 8'd43;
    capture(2);
    chk("ovf_cleared", 32'(OVERFLOW), 0);
    chk("short_len", 32'(FRAME_LEN), 2);
    gate_fall;
    drain(2, 0);

    // Empty gate window.
    saw  = 1'b0;
    GATE = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick;
      if (M_VALID) saw = 1'b1;
    end
    chk("empty_busy", 32'(BUSY), 1);
    GATE = 1'b0;
    tick;
    chk("empty_busy_low", 32'(BUSY), 0);
    chk("empty_len", 32'(FRAME_LEN), 0);
    for (int i = 0; i < 5; i++) begin
      if (M_VALID) saw = 1'b1;
      tick;
    end
    chk("empty_novalid", 32'(saw), 0);

    // Gate re-raised during DRAIN is ignored.
    stim[0] = 8'd10; stim[1] = 8'd20; stim[2] = 8'd30; stim[3] = 8'd40;
    capture(4);
    gate_fall;
    M_READY = 1'b0;
    tick;
    chk("stall_valid", 32'(M_VALID), 1);
    chk("stall_data", 32'(M_DATA), 10);
    GATE = 1'b1;
    tick;
    for (int i = 0; i < 3; i++) begin
      COUNTER = 8'd99;
      INTR    = 1'b1;
      tick;
    end
    INTR = 1'b0;
    GATE = 1'b0;
    tick;
    chk("gdd_len", 32'(FRAME_LEN), 4);
    chk("gdd_data", 32'(M_DATA), 10);
    drain(4, 0);
    tick;
    chk("gdd_idle", 32'(BUSY), 0);

    // Reset after two of four beats.
    stim[0] = 8'd5; stim[1] = 8'd6; stim[2] = 8'd7; stim[3] = 8'd8;
    capture(4);
    gate_fall;
    M_READY = 1'b1;
    tick;
    tick;
    tick;
    chk("mid_data", 32'(M_DATA), 7);
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_valid", 32'(M_VALID), 0);
    chk("arst_data", 32'(M_DATA), 0);
    chk("arst_last", 32'(M_LAST), 0);
    chk("arst_len", 32'(FRAME_LEN), 0);
    chk("arst_busy", 32'(BUSY), 0);
    M_READY = 1'b0;
    tick;
    RST_N = 1'b1;
    tick;
    tick;
    chk("post_rst_busy", 32'(BUSY), 0);

`ifdef COUNT_SUM_EN
    // Sum and threshold flag.
    stim[0] = 8'd1; stim[1] = 8'd2; stim[2] = 8'd2;
    capture(3);
    chk("sum_run", 32'(SUM), 5);
    gate_fall;
    chk("sum_a", 32'(SUM), 5);
    chk("state_bit_a", 32'(STATE_BIT), 1);
    drain(3, 0);
    stim[0] = 8'd1; stim[1] = 8'd1;
    capture(2);
    gate_fall;
    chk("sum_b", 32'(SUM), 2);
    chk("state_bit_b", 32'(STATE_BIT), 0);
    drain(2, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
